// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between four requesters and the rr_arbiter4 round-robin arbiter.
// The requester side uses the master modport; the arbiter uses the slave modport.
interface rr_arbiter4_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       busy;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  busy
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output busy
    );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: IDLE/GRANT/RELEASE FSM, rotating priority pointer, registered grants.
// Define RR_ARB_TIMEOUT_EN to cap each ownership at MAX_HOLD grant cycles.
module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arbiter4_if.slave arb
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        RELEASE = 2'b10
    } state_e;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_range
        $error("rr_arbiter4: MAX_HOLD must be in 1..255");
    end

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] gnt_q, gnt_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       busy_q, busy_d;
    logic       req_any;
    logic [1:0] win;
    logic       timeout_hit;

    // First set request at or above p, wrapping 3 -> 0.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] w;
        logic [1:0] idx;
        w = p;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) w = idx;
        end
        return w;
    endfunction

    assign req_any = |arb.req;
    assign win     = pick(arb.req, ptr_q);

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    logic [7:0] hold_q, hold_d;

    assign timeout_hit = (hold_q >= MAX_HOLD_C);

    // Loaded to 1 on entry to GRANT, counts while owned, saturates, zero elsewhere.
    always_comb begin
        hold_d = 8'd0;
        if (state_d == GRANT) begin
            if (state_q != GRANT)      hold_d = 8'd1;
            else if (hold_q != 8'hFF)  hold_d = hold_q + 8'd1;
            else                       hold_d = hold_q;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            IDLE: begin
                gnt_d = 4'b0000;
                if (req_any) begin
                    state_d = GRANT;
                    idx_d   = win;
                    gnt_d   = 4'b0001 << win;
                end
            end
            GRANT: begin
                if (!arb.req[idx_q] || timeout_hit) begin
                    state_d = RELEASE;
                    gnt_d   = 4'b0000;
                    ptr_d   = idx_q + 2'd1;
                end
            end
            RELEASE: begin
                gnt_d = 4'b0000;
                if (req_any) begin
                    state_d = GRANT;
                    idx_d   = win;
                    gnt_d   = 4'b0001 << win;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
        gnt_valid_d = |gnt_d;
        busy_d      = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            idx_q       <= 2'd0;
            gnt_q       <= 4'b0000;
            gnt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            hold_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            busy_q      <= busy_d;
`ifdef RR_ARB_TIMEOUT_EN
            hold_q      <= hold_d;
`endif
        end
    end

    assign arb.gnt       = gnt_q;
    assign arb.gnt_idx   = idx_q;
    assign arb.gnt_valid = gnt_valid_q;
    assign arb.busy      = busy_q;

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that shares one resource, such as the LED display path driven by the 4-to-2 encoder, between four request lines. Each requester holds its `req` bit high for as long as it needs the resource. The arbiter issues a registered one-hot grant and a 2-bit encoded owner index. Fairness comes from a rotating priority pointer. An optional hold timeout stops any one requester from monopolising the resource.

## Interface
- `MAX_HOLD`, default 8: maximum number of consecutive GRANT cycles per ownership. Legal range 1..255. Used only when the timeout is compiled in.

- `clk`  input  1: system clock; all state changes on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `req`  input  4: request lines, active-high, bit i is requester i; sampled on the rising edge of `clk`.
- `gnt`  output  4: one-hot grant, registered; all-zero when no owner.
- `gnt_idx`  output  2: binary index of the current owner; holds the last owner when `gnt` is 0.
- `gnt_valid`  output  1: high exactly when `gnt` is non-zero.
- `busy`  output  1: high in GRANT and RELEASE states.

## Operation
- The one clock is `clk`. Reset is asynchronous and active-low (`rst_n`).
- State machine with three states: IDLE, GRANT and RELEASE, encoded as 2-bit registers.
- IDLE:
  - If `req` is 0, stay in IDLE.
  - Otherwise pick the winner and go to GRANT with `gnt[winner]` set.
- Winner selection:
  - Search for the first set `req` bit, starting at index `ptr` and moving upward with wrap 3→0.
  - `ptr` is a 2-bit register.
- GRANT:
  - Owner is fixed.
  - If `req[owner]` is 0 when sampled, go to RELEASE.
  - With the timeout compiled in, also go to RELEASE when the hold counter reaches `MAX_HOLD`.
  - Requests from non-owners are ignored; they are neither lost nor latched.
- Leaving GRANT:
  - `ptr` is set to owner+1 mod 4, so the last owner becomes lowest priority.
  - `gnt` is cleared.
- RELEASE lasts exactly one cycle with `gnt` at 0:
  - If any `req` bit is set, select a winner as in IDLE and go to GRANT.
  - Otherwise go to IDLE.
- Hold counter:
  - 8 bits wide.
  - Loaded to 1 on entry to GRANT.
  - Increments each GRANT cycle and saturates.
  - Cleared in IDLE and RELEASE.
- Reset values:
  - State is IDLE.
  - `ptr`=0, so requester 0 has highest priority.
  - `gnt`=4'b0000, `gnt_idx`=2'b00, `gnt_valid`=0, `busy`=0, counter=0.
- Reset mid-grant: all outputs go to their reset values immediately, without waiting for a clock edge. Pending requests are re-arbitrated from `ptr`=0 after release.
- Illegal state encoding: recover to IDLE on the next edge.

## Timing
- Grant latency from IDLE: `req` sampled high at edge N, so `gnt` is high after edge N.
- Release: `req[owner]` sampled low at edge N, so `gnt` is 0 after edge N (RELEASE).
- The next grant appears after edge N+1, so the minimum gap between owners is one cycle with `gnt` low.
- A requester that drops and re-raises `req` within the RELEASE cycle competes with the rotated pointer; it does not keep ownership.
- Simultaneous requests are resolved only by `ptr`; there are no fixed priorities.
- With the timeout compiled in, ownership lasts at most `MAX_HOLD` cycles with `gnt` high. Then follows one RELEASE cycle.
  - If the timed-out owner still requests, it is re-granted only when no other requester is active.
- All outputs are registered; there are no combinational paths from `req` to any output.

## Configuration
- Macro: `RR_ARB_TIMEOUT_EN`.
- Defined:
  - The hold counter compare is active.
  - GRANT ends on `req[owner]` low or after `MAX_HOLD` cycles, whichever comes first.
- Undefined:
  - The counter and compare logic are removed and `MAX_HOLD` is ignored.
  - GRANT ends only when `req[owner]` goes low, so an owner may hold the resource indefinitely.

## Test plan
- Reset and single request:
  - Stimulus: `rst_n` low, then high; `req`=4'b0100 for 3 cycles, then 0.
  - Response: `gnt`=4'b0100 for 3 cycles, `gnt_idx`=2, then one cycle of `gnt`=0 with `busy`=1, then IDLE with `busy`=0.
- Rotation under full load:
  - Stimulus: `req`=4'b1111 held, each owner drops its bit for one cycle after 2 cycles of grant and then re-raises it.
  - Response: grant order 0,1,2,3,0, each separated by one zero-grant cycle.
- Pointer wrap:
  - Stimulus: owner 3 releases while `req`=4'b1011.
  - Response: the next grant goes to index 0, not 1.
- Timeout:
  - Stimulus: `RR_ARB_TIMEOUT_EN` defined, `MAX_HOLD`=4, `req`=4'b0011 held constant.
  - Response: `gnt`=0001 for 4 cycles, 1 gap cycle, then `gnt`=0010 for 4 cycles, repeating.
- No timeout build:
  - Stimulus: same as the timeout scenario, with the macro undefined.
  - Response: `gnt`=0001 held for 50 cycles.
- Asynchronous reset mid-grant:
  - Stimulus: `rst_n` pulsed low between clock edges while `gnt`=4'b1000.
  - Response: `gnt`, `gnt_valid` and `busy` are 0 before the next edge; after release with `req`=4'b1001, the grant goes to index 0.
